icache: RTL and testbench

Direct-mapped, read-only instruction cache sitting directly upstream of the fetch stage. It answers the fetch stage's SRAM-style `req / addr_ok / data_ok` handshake and refills missing lines over a burst read port toward the AXI bridge. Indexing is virtual (`inst_addr_vrtl[11:0]`) and tagging is physical (translated PC `[31:12]`). Hits return one cycle after the address handshake. Misses block until the refill completes.

---
 rtl/icache.sv | 161 ++++++++++++++++
 tb/tb_icache.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: virtually indexed, physically tagged,
// 16-byte lines, blocking refill over a burst read port.
module icache #(
    parameter int unsigned INDEX_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    // Fetch-side SRAM-style handshake
    input  logic               req,
    input  logic [INDEX_W-1:0] index,
    input  logic [3:0]         offset,
    input  logic [19:0]        tag,
    output logic               addr_ok,
    output logic               data_ok,
    output logic [31:0]        rdata,
    // Refill read port toward the bus bridge
    output logic               rd_req,
    output logic [2:0]         rd_type,
    output logic [31:0]        rd_addr,
    input  logic               rd_rdy,
    input  logic               ret_valid,
    input  logic               ret_last,
    input  logic [31:0]        ret_data
);

    localparam int unsigned Sets = 1 << INDEX_W;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StMiss,
        StRefill
    } state_e;

    state_e state_q, state_d;

    // Latched request; everything after the handshake works from these.
    logic [INDEX_W-1:0] lat_idx_q, lat_idx_d;
    logic [1:0]         lat_word_q, lat_word_d;
    logic [19:0]        lat_tag_q, lat_tag_d;

    logic [1:0]         cnt_q, cnt_d;
    logic [3:0][31:0]   line_q, line_d;
    logic [Sets-1:0]    valid_q, valid_d;

    logic [19:0]        tag_arr_q  [Sets];
    logic [3:0][31:0]   data_arr_q [Sets];

    logic               hit;
    logic               fill_we;
    logic [3:0][31:0]   merged;

    always_comb begin
        hit    = valid_q[lat_idx_q] && (tag_arr_q[lat_idx_q] == lat_tag_q);
        // Final beat is not yet in line_q, so fold it in for both the array write
        // and the bypassed read data.
        merged         = line_q;
        merged[cnt_q]  = ret_data;
    end

    always_comb begin
        state_d    = state_q;
        lat_idx_d  = lat_idx_q;
        lat_word_d = lat_word_q;
        lat_tag_d  = lat_tag_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        valid_d    = valid_q;
        fill_we    = 1'b0;

        addr_ok    = 1'b0;
        data_ok    = 1'b0;
        rdata      = 32'h0;
        rd_req     = 1'b0;
        rd_type    = 3'b100;
        rd_addr    = 32'h0;

        unique case (state_q)
            StIdle: begin
                addr_ok = req;
                if (req) begin
                    state_d = StLookup;
                end
            end

            StLookup: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = data_arr_q[lat_idx_q][lat_word_q];
                    addr_ok = req;
                    state_d = req ? StLookup : StIdle;
                end else begin
                    state_d = StMiss;
                end
            end

            StMiss: begin
                rd_req  = 1'b1;
                rd_addr = 32'({lat_tag_q, lat_idx_q, 4'b0000});
                cnt_d   = 2'd0;
                if (rd_rdy) begin
                    state_d = StRefill;
                end
            end

            StRefill: begin
                if (ret_valid) begin
                    line_d[cnt_q] = ret_data;
                    cnt_d         = cnt_q + 2'd1;
                    if (ret_last) begin
                        fill_we            = 1'b1;
                        valid_d[lat_idx_q] = 1'b1;
                        data_ok            = 1'b1;
                        rdata              = merged[lat_word_q];
                        cnt_d              = 2'd0;
                        state_d            = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (addr_ok) begin
            lat_idx_d  = index;
            lat_word_d = offset[3:2];
            lat_tag_d  = tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lat_idx_q  <= '0;
            lat_word_q <= 2'd0;
            lat_tag_q  <= 20'h0;
            cnt_q      <= 2'd0;
            line_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_idx_q  <= lat_idx_d;
            lat_word_q <= lat_word_d;
            lat_tag_q  <= lat_tag_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data contents need no reset; valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr_q[lat_idx_q]  <= lat_tag_q;
            data_arr_q[lat_idx_q] <= merged;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner sequences,
// and randomized accesses scored against a set/tag model backed by a synthetic memory.
module tb_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [7:0]  index;
    logic [3:0]  offset;
    logic [19:0] tag;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    int checks   = 0;
    int failures = 0;

    // What the cache should hold, tracked per set.
    bit          model_valid [256];
    logic [19:0] model_tag   [256];

    typedef struct {
        logic [7:0]  idx;
        logic [3:0]  off;
        logic [19:0] tg;
        int          rdy_wait;
        bit          exp_hit;
    } vec_t;

    vec_t vecs [11];

    icache #(.INDEX_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .index     (index),
        .offset    (offset),
        .tag       (tag),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Word at byte address a; odd multiplier keeps every word distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req       = 1'b0;
        index     = 8'($urandom);
        offset    = 4'($urandom);
        tag       = 20'($urandom);
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = $urandom;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 256; s++) begin
            model_valid[s] = 1'b0;
            model_tag[s]   = 20'h0;
        end
    endtask

    // One complete access starting in IDLE, just after a clock edge. Ends just after
    // the edge that follows the response.
    task automatic access(input logic [7:0] idx, input logic [3:0] off, input logic [19:0] tg,
                          input int rdy_wait, input bit exp_hit, input int gaps);
        logic [31:0] line;
        logic [31:0] exp_word;
        int          ng;
        line     = {tg, idx, 4'b0000};
        exp_word = mem_word(line | {28'h0, off[3:2], 2'b00});

        req    = 1'b1;
        index  = idx;
        offset = off;
        tag    = tg;
        @(negedge clk);
        chk("addr_ok_idle", {31'h0, addr_ok}, 32'd1);
        tick();
        // Scramble inputs to prove the request was latched.
        req    = 1'b0;
        index  = 8'($urandom);
        offset = 4'($urandom);
        tag    = 20'($urandom);
        @(negedge clk);
        if (exp_hit) begin
            chk("hit_data_ok", {31'h0, data_ok}, 32'd1);
            chk("hit_rdata", rdata, exp_word);
            chk("hit_no_rd_req", {31'h0, rd_req}, 32'd0);
            tick();
            return;
        end
        chk("miss_lookup_data_ok", {31'h0, data_ok}, 32'd0);
        chk("miss_lookup_rd_req", {31'h0, rd_req}, 32'd0);
        tick();

        for (int w = 0; w < rdy_wait; w++) begin
            req       = 1'($urandom_range(0, 1));
            ret_valid = 1'($urandom_range(0, 1));
            ret_last  = 1'b1;
            ret_data  = $urandom;
            @(negedge clk);
            chk("stall_rd_req", {31'h0, rd_req}, 32'd1);
            chk("stall_rd_addr", rd_addr, line);
            chk("stall_addr_ok", {31'h0, addr_ok}, 32'd0);
            chk("stall_data_ok", {31'h0, data_ok}, 32'd0);
            tick();
        end

        req       = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        rd_rdy    = 1'b1;
        @(negedge clk);
        chk("miss_rd_req", {31'h0, rd_req}, 32'd1);
        chk("miss_rd_addr", rd_addr, line);
        chk("miss_rd_type", {29'h0, rd_type}, 32'd4);
        tick();
        rd_rdy = 1'b0;

        for (int b = 0; b < 4; b++) begin
            ng = $urandom_range(0, gaps);
            for (int g = 0; g < ng; g++) begin
                ret_valid = 1'b0;
                req       = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("gap_data_ok", {31'h0, data_ok}, 32'd0);
                chk("gap_addr_ok", {31'h0, addr_ok}, 32'd0);
                chk("gap_rd_req", {31'h0, rd_req}, 32'd0);
                tick();
            end
            req       = 1'b0;
            ret_valid = 1'b1;
            ret_last  = (b == 3);
            ret_data  = mem_word(line | 32'(b * 4));
            @(negedge clk);
            if (b < 3) begin
                chk("beat_data_ok", {31'h0, data_ok}, 32'd0);
                chk("beat_rdata", rdata, 32'h0);
            end else begin
                chk("last_data_ok", {31'h0, data_ok}, 32'd1);
                chk("last_rdata", rdata, exp_word);
            end
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tg;
    endtask

    initial begin
        vecs[0]  = '{8'h10, 4'h4, 20'h1C000, 0, 1'b0};
        vecs[1]  = '{8'h10, 4'h4, 20'h1C000, 0, 1'b1};
        vecs[2]  = '{8'h10, 4'hF, 20'h1C000, 0, 1'b1};
        vecs[3]  = '{8'h10, 4'h4, 20'h1C001, 1, 1'b0};
        vecs[4]  = '{8'h10, 4'h8, 20'h1C001, 0, 1'b1};
        vecs[5]  = '{8'h10, 4'h4, 20'h1C000, 0, 1'b0};
        vecs[6]  = '{8'h20, 4'hC, 20'h00ABC, 5, 1'b0};
        vecs[7]  = '{8'h20, 4'h1, 20'h00ABC, 0, 1'b1};
        vecs[8]  = '{8'hFF, 4'hC, 20'hFFFFF, 2, 1'b0};
        vecs[9]  = '{8'h00, 4'h0, 20'h00000, 0, 1'b0};
        vecs[10] = '{8'h00, 4'h0, 20'h00000, 0, 1'b1};

        drive_idle();
        clear_model();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_addr_ok", {31'h0, addr_ok}, 32'd0);
        chk("rst_data_ok", {31'h0, data_ok}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rd_req", {31'h0, rd_req}, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_data_ok", {31'h0, data_ok}, 32'd0);
        chk("post_rst_rd_req", {31'h0, rd_req}, 32'd0);
        tick();

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].idx, vecs[i].off, vecs[i].tg, vecs[i].rdy_wait, vecs[i].exp_hit, 1);
        end

        // Back-to-back hits across the line at set 0x10, tag 0x1C000.
        for (int k = 0; k < 5; k++) begin
            req    = (k < 4);
            index  = 8'h10;
            offset = 4'(k * 4);
            tag    = 20'h1C000;
            @(negedge clk);
            chk("b2b_addr_ok", {31'h0, addr_ok}, (k < 4) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk("b2b_data_ok", {31'h0, data_ok}, 32'd1);
                chk("b2b_rdata", rdata, mem_word(32'h1C00_0100 + 32'((k - 1) * 4)));
            end else begin
                chk("b2b_first_data_ok", {31'h0, data_ok}, 32'd0);
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        chk("b2b_tail_data_ok", {31'h0, data_ok}, 32'd0);
        tick();

        // Reset in the middle of a refill, then stale beats.
        req    = 1'b1;
        index  = 8'h30;
        offset = 4'h8;
        tag    = 20'h12345;
        @(negedge clk);
        chk("mid_addr_ok", {31'h0, addr_ok}, 32'd1);
        tick();
        req = 1'b0;
        tick();
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ret_valid = 1'b1;
            ret_last  = 1'b0;
            ret_data  = mem_word(32'h1234_5300 + 32'(b * 4));
            @(negedge clk);
            chk("mid_beat_data_ok", {31'h0, data_ok}, 32'd0);
            tick();
        end
        ret_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        for (int b = 2; b < 4; b++) begin
            ret_valid = 1'b1;
            ret_last  = (b == 3);
            ret_data  = mem_word(32'h1234_5300 + 32'(b * 4));
            @(negedge clk);
            chk("late_beat_data_ok", {31'h0, data_ok}, 32'd0);
            chk("late_beat_rd_req", {31'h0, rd_req}, 32'd0);
            chk("late_beat_addr_ok", {31'h0, addr_ok}, 32'd0);
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        access(8'h30, 4'h8, 20'h12345, 1, 1'b0, 1);
        access(8'h10, 4'h4, 20'h1C000, 0, 1'b0, 1);

        // Randomized accesses against the model.
        for (int n = 0; n < 150; n++) begin
            logic [7:0]  ridx;
            logic [19:0] rtg;
            logic [3:0]  roff;
            int          sel;
            bit          exp_hit;
            ridx = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
            sel  = $urandom_range(0, 2);
            rtg  = (sel == 0) ? 20'h1C000 : (sel == 1) ? 20'h1C001 : 20'hABCDE;
            roff = 4'($urandom);
            exp_hit = model_valid[ridx] && (model_tag[ridx] == rtg);
            access(ridx, roff, rtg, $urandom_range(0, 3), exp_hit, 2);
            drive_idle();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                chk("rand_idle_data_ok", {31'h0, data_ok}, 32'd0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
